sisc_fetch: RTL and testbench

- Instruction-side responder to the SISC control FSM. The FSM issues ir_load, pc_sel and br_sel; this block answers with the decoded opcode, mm and operand fields.
- Owns the program counter (PC) and instruction register (IR).
- Runs a req/ack handshake to instruction memory, which may take a variable number of cycles.
- Sits between ctrl and the instruction memory. Its outputs feed ctrl and the datapath register file.

---
 rtl/sisc_fetch_if.sv | 34 +++
 rtl/sisc_fetch.sv | 125 ++++++++++++
 tb/tb_sisc_fetch.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sisc_fetch_if.sv
// Control/instruction-memory bundle between the SISC ctrl FSM, the fetch unit and instruction memory.
// The fetch unit takes the slave modport; ctrl plus memory (or a testbench) take the master modport.
interface sisc_fetch_if #(
  parameter int AW = 16,
  parameter int IW = 32
);
  logic          ir_load;
  logic          pc_sel;
  logic          br_sel;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [3:0]    opcode;
  logic [3:0]    mm;
  logic [3:0]    rd;
  logic [3:0]    rs;
  logic [3:0]    rt;
  logic [15:0]   imm;
  logic [AW-1:0] pc;
  logic          ir_valid;
  logic          busy;
  logic          fetch_err;

  modport master (
    output ir_load, pc_sel, br_sel, imem_ack, imem_rdata,
    input  imem_req, imem_addr, opcode, mm, rd, rs, rt, imm, pc, ir_valid, busy, fetch_err
  );

  modport slave (
    input  ir_load, pc_sel, br_sel, imem_ack, imem_rdata,
    output imem_req, imem_addr, opcode, mm, rd, rs, rt, imm, pc, ir_valid, busy, fetch_err
  );
endinterface

// File: rtl/sisc_fetch.sv
// SISC fetch unit: owns PC and IR, fetches over a req/ack handshake, decodes IR fields for ctrl.
// Optional macro FETCH_TIMEOUT_EN adds a TIMEOUT-cycle ack watchdog with a sticky fetch_err flag.
module sisc_fetch #(
  parameter int AW      = 16,
  parameter int IW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     rst_f,
  sisc_fetch_if.slave bus
);
  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] pend_tgt_q, pend_tgt_d;
  logic          pend_q, pend_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] target;
  logic          timeout;

  // Branch target always uses the imm of the IR currently held and the current PC.
  assign target = bus.br_sel ? (pc_q + AW'(signed'(ir_q[15:0])))
                             : AW'(ir_q[15:0]);

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign timeout = (state_q == REQ) && !bus.imem_ack && (cnt_q == 4'(TIMEOUT - 1));
  assign cnt_d   = (state_q == REQ) ? cnt_q + 4'd1 : 4'd0;
  assign err_d   = err_q | timeout;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.fetch_err = err_q;
`else
  assign timeout       = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    ir_d       = ir_q;
    valid_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.pc_sel) pc_d = target;
        if (bus.ir_load) begin
          state_d = REQ;
          addr_d  = bus.pc_sel ? target : pc_q;
          pend_d  = 1'b0;
        end
      end
      REQ: begin
        if (bus.pc_sel) begin
          pend_d     = 1'b1;
          pend_tgt_d = target;
        end
        if (bus.imem_ack) begin
          state_d = IDLE;
          ir_d    = bus.imem_rdata;
          valid_d = 1'b1;
          pend_d  = 1'b0;
          // A branch strobe arriving with the ack still wins over the sequential PC.
          if (bus.pc_sel)  pc_d = target;
          else if (pend_q) pc_d = pend_tgt_q;
          else             pc_d = addr_q + AW'(1);
        end else if (timeout) begin
          state_d = IDLE;
          ir_d    = '0;
          valid_d = 1'b1;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      ir_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.imem_req  = (state_q == REQ);
  assign bus.busy      = (state_q == REQ);
  assign bus.imem_addr = addr_q;
  assign bus.pc        = pc_q;
  assign bus.ir_valid  = valid_q;
  assign bus.opcode    = ir_q[31:28];
  assign bus.mm        = ir_q[27:24];
  assign bus.rd        = ir_q[23:20];
  assign bus.rs        = ir_q[19:16];
  assign bus.rt        = ir_q[15:12];
  assign bus.imm       = ir_q[15:0];
endmodule

// File: tb/tb_sisc_fetch.sv
// Self-checking bench for sisc_fetch: directed vectors, corner sequences and a randomized
// run against a transaction-level model of PC/IR behaviour.
module tb_sisc_fetch;
  logic clk;
  logic rst_f;
  int   pass_cnt;
  int   total_cnt;

  logic [15:0] m_pc;
  logic [31:0] m_ir;

  sisc_fetch_if #(.AW(16), .IW(32)) bus ();

  sisc_fetch #(.AW(16), .IW(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    logic [15:0] exp_pc;
    logic [3:0]  exp_op;
    logic [3:0]  exp_mm;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_rs;
    logic [3:0]  exp_rt;
    logic [15:0] exp_imm;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] tgt(input bit rel);
    int off;
    if (!rel) return m_ir[15:0];
    off = int'($signed(m_ir[15:0]));
    return 16'(int'(m_pc) + off);
  endfunction

  task automatic branch(input bit rel);
    logic [15:0] nxt;
    nxt = tgt(rel);
    bus.pc_sel = 1'b1;
    bus.br_sel = rel;
    tick();
    bus.pc_sel = 1'b0;
    m_pc = nxt;
    $display("branch rel=%0d pc=%h", rel, bus.pc);
    chk("branch_pc", 32'(bus.pc), 32'(m_pc));
    chk("branch_busy", 32'(bus.busy), 32'd0);
  endtask

  // One complete fetch; br_at is the wait-cycle index of a pc_sel (with a stray ir_load), -1 for none.
  task automatic fetch(input logic [31:0] rdata, input int waits, input int br_at, input bit bsel,
                       input bit sim_sel, input bit sim_bsel);
    logic [15:0] addr;
    logic [15:0] pend;
    bit          has_pend;
    has_pend = 1'b0;
    pend     = '0;
    addr     = m_pc;
    bus.ir_load = 1'b1;
    bus.pc_sel  = sim_sel;
    bus.br_sel  = sim_bsel;
    if (sim_sel) begin
      addr = tgt(sim_bsel);
      m_pc = addr;
    end
    tick();
    bus.ir_load = 1'b0;
    bus.pc_sel  = 1'b0;
    chk("req_high", 32'(bus.imem_req), 32'd1);
    chk("req_addr", 32'(bus.imem_addr), 32'(addr));
    chk("req_pc", 32'(bus.pc), 32'(m_pc));
    for (int w = 0; w < waits; w++) begin
      if (w == br_at) begin
        bus.pc_sel  = 1'b1;
        bus.br_sel  = bsel;
        bus.ir_load = 1'b1;
        pend        = tgt(bsel);
        has_pend    = 1'b1;
      end
      tick();
      bus.pc_sel  = 1'b0;
      bus.ir_load = 1'b0;
      chk("wait_req", 32'(bus.imem_req), 32'd1);
      chk("wait_addr", 32'(bus.imem_addr), 32'(addr));
      chk("wait_valid", 32'(bus.ir_valid), 32'd0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    m_ir = rdata;
    m_pc = has_pend ? pend : addr + 16'd1;
    $display("fetch addr=%h word=%h waits=%0d pc=%h op=%h", addr, rdata, waits, bus.pc, bus.opcode);
    chk("ack_valid", 32'(bus.ir_valid), 32'd1);
    chk("ack_pc", 32'(bus.pc), 32'(m_pc));
    chk("ack_opcode", 32'(bus.opcode), 32'(m_ir[31:28]));
    chk("ack_mm", 32'(bus.mm), 32'(m_ir[27:24]));
    chk("ack_rd", 32'(bus.rd), 32'(m_ir[23:20]));
    chk("ack_rs", 32'(bus.rs), 32'(m_ir[19:16]));
    chk("ack_rt", 32'(bus.rt), 32'(m_ir[15:12]));
    chk("ack_imm", 32'(bus.imm), 32'(m_ir[15:0]));
    chk("ack_req_low", 32'(bus.imem_req), 32'd0);
    tick();
    chk("post_valid", 32'(bus.ir_valid), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic set_pc(input logic [15:0] v);
    fetch({16'h0000, v}, 0, -1, 1'b0, 1'b0, 1'b0);
    branch(1'b0);
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    vecs[0] = '{32'h8123_0005, 0, 16'h0011, 4'h8, 4'h1, 4'h2, 4'h3, 4'h0, 16'h0005};
    vecs[1] = '{32'hF000_0000, 2, 16'h0012, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
    vecs[2] = '{32'h1ABC_DEF0, 1, 16'h0013, 4'h1, 4'hA, 4'hB, 4'hC, 4'hD, 16'hDEF0};

    rst_f = 1'b0;
    bus.ir_load = 1'b0;
    bus.pc_sel = 1'b0;
    bus.br_sel = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    m_pc = '0;
    m_ir = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_opcode", 32'(bus.opcode), 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.ir_valid), 32'd0);
    chk("rst_err", 32'(bus.fetch_err), 32'd0);
    rst_f = 1'b1;
    tick();

    set_pc(16'h0010);
    for (int i = 0; i < 3; i++) begin
      fetch(vecs[i].rdata, vecs[i].waits, -1, 1'b0, 1'b0, 1'b0);
      chk("vec_pc", 32'(bus.pc), 32'(vecs[i].exp_pc));
      chk("vec_opcode", 32'(bus.opcode), 32'(vecs[i].exp_op));
      chk("vec_mm", 32'(bus.mm), 32'(vecs[i].exp_mm));
      chk("vec_rd", 32'(bus.rd), 32'(vecs[i].exp_rd));
      chk("vec_rs", 32'(bus.rs), 32'(vecs[i].exp_rs));
      chk("vec_rt", 32'(bus.rt), 32'(vecs[i].exp_rt));
      chk("vec_imm", 32'(bus.imm), 32'(vecs[i].exp_imm));
    end

    set_pc(16'h0010);
    fetch(32'h0000_FFFE, 0, -1, 1'b0, 1'b0, 1'b0);
    branch(1'b1);
    chk("rel_branch", 32'(bus.pc), 32'h0000_000F);
    fetch(32'h0000_0040, 0, -1, 1'b0, 1'b0, 1'b0);
    branch(1'b0);
    chk("abs_branch", 32'(bus.pc), 32'h0000_0040);

    set_pc(16'h001F);
    fetch(32'h0000_0100, 0, -1, 1'b0, 1'b0, 1'b0);
    fetch(32'hA5A5_A5A5, 3, 1, 1'b0, 1'b0, 1'b0);
    chk("wait_branch_pc", 32'(m_pc), 32'h0000_0100);

    set_pc(16'hFFFF);
    fetch(32'h0000_0200, 0, -1, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc", 32'(bus.pc), 32'h0000_0000);
    fetch(32'h3456_7890, 0, -1, 1'b0, 1'b1, 1'b0);
    chk("sim_sel_pc", 32'(bus.pc), 32'h0000_0201);

    for (int i = 0; i < 40; i++) begin
      int  w;
      int  b;
      w = int'($urandom_range(0, 4));
      b = (w > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, w - 1)) : -1;
      if ($urandom_range(0, 3) == 0) branch(1'($urandom));
      fetch($urandom, w, b, 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

`ifdef FETCH_TIMEOUT_EN
    set_pc(16'h002F);
    fetch(32'h7000_0000, 0, -1, 1'b0, 1'b0, 1'b0);
    bus.ir_load = 1'b1;
    tick();
    bus.ir_load = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_req_before", 32'(bus.imem_req), 32'd1);
    tick();
    $display("timeout pc=%h err=%0d", bus.pc, bus.fetch_err);
    chk("to_req_low", 32'(bus.imem_req), 32'd0);
    chk("to_opcode", 32'(bus.opcode), 32'd0);
    chk("to_valid", 32'(bus.ir_valid), 32'd1);
    chk("to_err", 32'(bus.fetch_err), 32'd1);
    chk("to_pc", 32'(bus.pc), 32'h0000_0030);
    tick();
    chk("to_err_sticky", 32'(bus.fetch_err), 32'd1);
`else
    chk("err_tied_low", 32'(bus.fetch_err), 32'd0);
`endif

    set_pc(16'h0055);
    fetch(32'h9000_0000, 0, -1, 1'b0, 1'b0, 1'b0);
    bus.ir_load = 1'b1;
    tick();
    bus.ir_load = 1'b0;
    chk("mid_req_high", 32'(bus.imem_req), 32'd1);
    #3;
    rst_f = 1'b0;
    #1;
    $display("async reset mid-fetch pc=%h req=%0d", bus.pc, bus.imem_req);
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_pc", 32'(bus.pc), 32'd0);
    chk("mid_rst_opcode", 32'(bus.opcode), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_err", 32'(bus.fetch_err), 32'd0);
    @(posedge clk);
    #2;
    rst_f = 1'b1;
    tick();
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.imem_ack = 1'b0;
    chk("late_ack_valid", 32'(bus.ir_valid), 32'd0);
    chk("late_ack_opcode", 32'(bus.opcode), 32'd0);
    chk("late_ack_pc", 32'(bus.pc), 32'd0);
    chk("late_ack_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
